// File: rtl/adc_spi_reader_pkg.sv
// adc_spi_reader_pkg: FSM encodings and ADC frame constants shared by the TSAL ADC reader
package adc_spi_reader_pkg;
  localparam int DATA_W = 8;
  localparam int FRAME_BITS_DEF = 16;
  localparam int LEAD_BITS_DEF = 3;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/adc_spi_reader_sample_avg4.sv
// adc_spi_reader_sample_avg4: averages groups of 4 raw samples (built only with ADC_AVG4_EN)
`ifdef ADC_AVG4_EN
module adc_spi_reader_sample_avg4
  import adc_spi_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] raw,
  input  logic              raw_valid,
  input  logic              clear,
  output logic [DATA_W-1:0] avg,
  output logic              avg_valid
);
  logic [DATA_W+1:0] acc;
  logic [DATA_W+1:0] sum;
  logic [1:0]        n;
  always_comb sum = acc + {2'b00, raw};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      acc <= '0;
      n <= '0;
      avg <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= raw_valid && n == 2'd3 && !clear;
      if (clear) begin
        acc <= '0;
        n <= '0;
      end else if (raw_valid) begin
        acc <= n == 2'd3 ? '0 : sum;
        n <= n + 2'd1;
        if (n == 2'd3) avg <= sum[DATA_W+1:2];
      end
    end
endmodule
`endif

// File: rtl/adc_spi_reader.sv
// adc_spi_reader: periodic 8-bit SPI ADC sampler for the TSAL path; ADC_AVG4_EN enables 4-sample averaging
module adc_spi_reader
  import adc_spi_reader_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 8000,
  parameter int FRAME_BITS    = FRAME_BITS_DEF,
  parameter int LEAD_BITS     = LEAD_BITS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              adc_miso,
  output logic              adc_sclk,
  output logic              adc_cs_n,
  output logic [DATA_W-1:0] data,
  output logic              data_ready,
  output logic              busy
);
  localparam int PW = $clog2(SAMPLE_PERIOD + 1);
  localparam int DW = $clog2(2 * CLK_DIV + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);
  logic [1:0]        state;
  logic [1:0]        nxt;
  logic [PW-1:0]     pc;
  logic [DW-1:0]     d;
  logic [BW-1:0]     b;
  logic [DATA_W-1:0] sr;
  logic              start;
  logic              div_end;
  logic              cap;
  always_comb begin
    start = enable && pc == '0 && state == ST_IDLE;
    div_end = d == (state == ST_SETUP ? DW'(CLK_DIV - 1) : DW'(2 * CLK_DIV - 1));
    cap = state == ST_SHIFT && d == DW'(CLK_DIV) && b >= BW'(LEAD_BITS) && b < BW'(LEAD_BITS + DATA_W);
    nxt = state == ST_IDLE  ? (start ? ST_SETUP : ST_IDLE) :
          state == ST_SETUP ? (div_end ? ST_SHIFT : ST_SETUP) :
          state == ST_SHIFT ? (div_end && b == BW'(FRAME_BITS - 1) ? ST_DONE : ST_SHIFT) :
          ST_IDLE;
  end
  // SCLK is low for the first CLK_DIV cycles of each bit period, so the sampling edge is at d == CLK_DIV
  assign adc_cs_n = !(state == ST_SETUP || state == ST_SHIFT);
  assign adc_sclk = !(state == ST_SHIFT && d < DW'(CLK_DIV));
  assign busy = state != ST_IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= ST_IDLE;
      pc <= '0;
      d <= '0;
      b <= '0;
      sr <= '0;
    end else begin
      state <= nxt;
      pc <= (!enable || pc == PW'(SAMPLE_PERIOD - 1)) ? '0 : pc + 1'b1;
      d <= ((state == ST_SETUP || state == ST_SHIFT) && !div_end) ? d + 1'b1 : '0;
      b <= state != ST_SHIFT ? '0 : b + BW'(div_end);
      if (cap) sr <= {sr[DATA_W-2:0], adc_miso};
    end
`ifdef ADC_AVG4_EN
  adc_spi_reader_sample_avg4 u_avg (
    .clk      (clk),
    .rst      (rst),
    .raw      (sr),
    .raw_valid(state == ST_DONE),
    .clear    (!enable),
    .avg      (data),
    .avg_valid(data_ready)
  );
`else
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      data <= '0;
      data_ready <= 1'b0;
    end else begin
      data_ready <= state == ST_DONE;
      if (state == ST_DONE) data <= sr;
    end
`endif
endmodule

// File: tb/tb_adc_spi_reader.sv
// tb_adc_spi_reader: self-checking bench with a behavioural ADC081S021 model and frame/timing monitor
module tb_adc_spi_reader;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       adc_miso = 1'b0;
  logic       adc_sclk;
  logic       adc_cs_n;
  logic [7:0] data;
  logic       data_ready;
  logic       busy;

  adc_spi_reader dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .adc_miso  (adc_miso),
    .adc_sclk  (adc_sclk),
    .adc_cs_n  (adc_cs_n),
    .data      (data),
    .data_ready(data_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ADC model: the frame word is shifted out MSB first, one bit per SCLK falling edge
  logic [15:0] word = 16'h0000;
  int idx = 0;
  always @(negedge adc_cs_n or negedge adc_sclk)
    if (adc_sclk) idx = 0;
    else if (!adc_cs_n && idx < 16) begin
      adc_miso = word[15-idx];
      idx++;
    end

  logic prev_cs = 1'b1;
  logic prev_sclk = 1'b1;
  logic prev_dr = 1'b0;
  int falls_q[$];
  int rises_q[$];
  int rises = 0;
  int sclk_bad = 0;
  int nstrobe = 0;
  int long_strobe = 0;
  always @(negedge clk) begin
    if (prev_cs && !adc_cs_n) begin
      falls_q.push_back(cyc);
      rises = 0;
    end
    if (!prev_cs && adc_cs_n) rises_q.push_back(rises);
    if (!adc_cs_n && !prev_sclk && adc_sclk) rises++;
    if (adc_cs_n && !adc_sclk) sclk_bad++;
    if (data_ready) nstrobe++;
    if (data_ready && prev_dr) long_strobe++;
    prev_cs = adc_cs_n;
    prev_sclk = adc_sclk;
    prev_dr = data_ready;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_strobe(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = data_ready;
    end
    if (!ok) check("strobe_timeout", 0, 1);
  endtask

  task automatic wait_rises(input int n);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = !adc_cs_n && rises >= n;
    end
    if (!ok) check("rise_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = !busy;
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  task automatic kick(input logic [15:0] w);
    @(negedge clk);
    enable = 1'b0;
    word = w;
    @(negedge clk);
    enable = 1'b1;
  endtask

  function automatic int slot(input logic [15:0] w);
    return int'((w >> 5) & 16'h00FF);
  endfunction

  typedef struct {
    logic [15:0] w;
    logic [7:0]  exp;
    string       name;
  } vec_t;
  vec_t v[8];

  initial begin
    bit ok;
    int n0, r0, s0, bad;
    logic [15:0] w;
    v[0] = '{w: 16'h0C80, exp: 8'h64, name: "slot_0x64"};
    v[1] = '{w: 16'h001F, exp: 8'h00, name: "slot_0x00_trail1"};
    v[2] = '{w: 16'h003F, exp: 8'h01, name: "slot_0x01_trail1"};
    v[3] = '{w: 16'h101F, exp: 8'h80, name: "slot_0x80_trail1"};
    v[4] = '{w: 16'h1FFF, exp: 8'hFF, name: "slot_0xFF_trail1"};
    v[5] = '{w: 16'hE000, exp: 8'h00, name: "slot_0x00_lead1"};
    v[6] = '{w: 16'hEB5F, exp: 8'h5A, name: "slot_0x5A_lead_trail1"};
    v[7] = '{w: 16'h14A0, exp: 8'hA5, name: "slot_0xA5"};
    repeat (3) @(negedge clk);
    check("rst_cs_n", adc_cs_n, 1);
    check("rst_sclk", adc_sclk, 1);
    check("rst_data", data, 0);
    check("rst_ready", data_ready, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
`ifdef ADC_AVG4_EN
    begin
      int samp[4] = '{10, 20, 30, 41};
      s0 = nstrobe;
      @(negedge clk);
      word = 16'(samp[0] << 5);
      enable = 1'b1;
      for (int k = 0; k < 4; k++) begin
        r0 = rises_q.size();
        ok = 1'b0;
        for (int i = 0; i < 10000 && !ok; i++) begin
          @(negedge clk);
          #1;
          ok = rises_q.size() > r0;
        end
        if (!ok) check("avg_frame_timeout", 0, 1);
        if (k < 3) begin
          check("avg_no_early_strobe", nstrobe - s0, 0);
          word = 16'(samp[k+1] << 5);
        end
      end
      wait_strobe(10, ok);
      if (ok) check("avg_data", data, (samp[0] + samp[1] + samp[2] + samp[3]) / 4);
      #1;
      check("avg_strobe_count", nstrobe - s0, 1);
      enable = 1'b0;
    end
`else
    for (int i = 0; i < 8; i++) begin
      kick(v[i].w);
      wait_strobe(300, ok);
      if (ok) begin
        check(v[i].name, data, v[i].exp);
        check("latency", cyc - falls_q[$], 133);
        if (i == 0) begin
          check("busy_at_strobe", busy, 0);
          repeat (10) @(negedge clk);
          check("data_held", data, v[i].exp);
          check("ready_low_after", data_ready, 0);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      w = 16'($urandom);
      kick(w);
      wait_strobe(300, ok);
      if (ok) check("random_frame", data, slot(w));
    end
    // free run: period spacing, SCLK count, SCLK idle level
    @(negedge clk);
    enable = 1'b0;
    word = 16'($urandom);
    n0 = falls_q.size();
    r0 = rises_q.size();
    s0 = nstrobe;
    @(negedge clk);
    enable = 1'b1;
    repeat (40200) @(negedge clk);
    enable = 1'b0;
    check("freerun_falls", falls_q.size() - n0, 6);
    bad = 0;
    for (int i = n0 + 1; i < falls_q.size(); i++) if (falls_q[i] - falls_q[i-1] != 8000) bad++;
    check("freerun_spacing_errs", bad, 0);
    check("freerun_frames", rises_q.size() - r0, 6);
    bad = 0;
    for (int i = r0; i < rises_q.size(); i++) if (rises_q[i] != 16) bad++;
    check("sclk_rises_errs", bad, 0);
    check("freerun_strobes", nstrobe - s0, 6);
    check("freerun_data", data, slot(word));
    check("sclk_high_when_idle", sclk_bad, 0);
    // enable dropped mid-SHIFT
    wait_idle(300);
    w = 16'(($urandom & 32'hE01F) | (32'hC3 << 5));
    kick(w);
    wait_rises(5);
    enable = 1'b0;
    wait_strobe(300, ok);
    if (ok) check("drop_enable_data", data, 8'hC3);
    n0 = falls_q.size();
    repeat (20000) @(negedge clk);
    check("no_start_disabled", falls_q.size() - n0, 0);
    enable = 1'b1;
    @(negedge clk);
    check("restart_next_cycle", adc_cs_n, 0);
    // reset mid-frame
    wait_rises(8);
    s0 = nstrobe;
    rst = 1'b0;
    #1;
    check("midrst_cs_n", adc_cs_n, 1);
    check("midrst_sclk", adc_sclk, 1);
    check("midrst_data", data, 0);
    check("midrst_ready", data_ready, 0);
    check("midrst_busy", busy, 0);
    repeat (5) @(negedge clk);
    word = 16'h3C << 5;
    rst = 1'b1;
    wait_strobe(300, ok);
    if (ok) check("post_rst_data", data, 8'h3C);
    #1;
    check("post_rst_strobes", nstrobe - s0, 1);
    check("single_cycle_strobe", long_strobe, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
